seg7_scan_driver: RTL and testbench



---
 rtl/seg7_pkg.sv | 22 ++
 rtl/seg7_glyph.sv | 17 +
 rtl/seg7_scan_driver.sv | 182 ++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan driver: glyph constants and FSM states.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HEX,
        DEC,
        COMMIT
    } state_e;

    // Segment order is a..g from left to right, active-low.
    localparam logic [0:6] GLYPH_BLANK = 7'b1111111;
    localparam logic [0:6] GLYPH_DASH  = 7'b1111110;

    localparam logic [0:6] GLYPH_HEX [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

endpackage

// File: rtl/seg7_glyph.sv
// Nibble to active-low segment decoder; dash overrides blank, blank overrides the nibble.
module seg7_glyph
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    input  logic       blank,
    input  logic       dash,
    output logic [0:6] seg
);

    always_comb begin
        seg = GLYPH_HEX[nib];
        if (blank) seg = GLYPH_BLANK;
        if (dash)  seg = GLYPH_DASH;
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment driver: latches a value, converts it to hex or BCD digits,
// commits the result atomically and scans the digits with registered outputs.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int DATA_W      = 16,
    parameter int REFRESH_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] value,
    input  logic              mode,
    input  logic [DIGITS-1:0] dp,
    input  logic              blank_lz,
    output logic              busy,
    output logic [0:6]        disp,
    output logic              dp_n,
    output logic [DIGITS-1:0] an
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int EXT_W = (DATA_W > BCD_W) ? DATA_W : BCD_W;
    localparam int CNT_W = $clog2(DATA_W);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PRE_W = $clog2(REFRESH_DIV);

    state_e                   state_q, state_d;
    logic [DATA_W-1:0]        val_q, val_d;
    logic [BCD_W-1:0]         bcd_q, bcd_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     ovf_q, ovf_d;
    logic [DIGITS-1:0]        dpc_q, dpc_d;
    logic                     blz_q, blz_d;
    logic [DIGITS-1:0][3:0]   dig_q, dig_d;
    logic [DIGITS-1:0]        blank_q, blank_d;
    logic [DIGITS-1:0]        dpr_q, dpr_d;
    logic                     dovf_q, dovf_d;
    logic [PRE_W-1:0]         pre_q, pre_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [0:6]               disp_q, disp_d;
    logic                     dpn_q, dpn_d;
    logic [DIGITS-1:0]        an_q, an_d;

    logic [EXT_W-1:0]         val_ext;
    logic [BCD_W-1:0]         adj;
    logic [DIGITS-1:0]        lz_blank;
    logic                     seen_nz;
    logic [0:6]               glyph;

    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < DIGITS; i++) begin
            if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    assign val_ext = EXT_W'(val_q);
    assign adj     = dabble_adjust(bcd_q);

    // Digits above the most significant nonzero digit are leading zeros; digit 0 always shows.
    always_comb begin
        seen_nz  = 1'b0;
        lz_blank = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (bcd_q[4*i +: 4] != 4'd0) seen_nz = 1'b1;
            lz_blank[i] = blz_q & ~ovf_q & ~seen_nz;
        end
    end

    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        dpc_d   = dpc_q;
        blz_d   = blz_q;
        dig_d   = dig_q;
        blank_d = blank_q;
        dpr_d   = dpr_q;
        dovf_d  = dovf_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    val_d   = value;
                    dpc_d   = dp;
                    blz_d   = blank_lz;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = mode ? DEC : HEX;
                end
            end
            HEX: begin
                bcd_d   = val_ext[BCD_W-1:0];
                ovf_d   = (val_ext > EXT_W'({BCD_W{1'b1}}));
                state_d = COMMIT;
            end
            DEC: begin
                // A carry out of the top BCD digit means the value needs more digits.
                bcd_d = {adj[BCD_W-2:0], val_q[DATA_W-1]};
                ovf_d = ovf_q | adj[BCD_W-1];
                val_d = val_q << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DATA_W - 1)) state_d = COMMIT;
            end
            COMMIT: begin
                dig_d   = bcd_q;
                dpr_d   = dpc_q;
                dovf_d  = ovf_q;
                blank_d = lz_blank;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    seg7_glyph u_glyph (
        .nib   (dig_q[idx_q]),
        .blank (blank_q[idx_q]),
        .dash  (dovf_q),
        .seg   (glyph)
    );

    always_comb begin
        pre_d = pre_q + PRE_W'(1);
        idx_d = idx_q;
        if (pre_q == PRE_W'(REFRESH_DIV - 1)) begin
            pre_d = '0;
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
        an_d   = ~(DIGITS'(1) << idx_q);
        disp_d = glyph;
        dpn_d  = ~dpr_q[idx_q];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dig_q   <= '0;
            blank_q <= '1;
            dpr_q   <= '0;
            dovf_q  <= 1'b0;
            pre_q   <= '0;
            idx_q   <= '0;
            disp_q  <= GLYPH_BLANK;
            dpn_q   <= 1'b1;
            an_q    <= '1;
        end else begin
            state_q <= state_d;
            dig_q   <= dig_d;
            blank_q <= blank_d;
            dpr_q   <= dpr_d;
            dovf_q  <= dovf_d;
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            disp_q  <= disp_d;
            dpn_q   <= dpn_d;
            an_q    <= an_d;
        end
    end

    // Conversion datapath is always initialised on load accept, so it carries no reset.
    always_ff @(posedge clk) begin
        val_q <= val_d;
        bcd_q <= bcd_d;
        cnt_q <= cnt_d;
        ovf_q <= ovf_d;
        dpc_q <= dpc_d;
        blz_q <= blz_d;
    end

    assign busy = (state_q != IDLE);
    assign disp = disp_q;
    assign dp_n = dpn_q;
    assign an   = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed and randomized bench for seg7_scan_driver with an arithmetic digit model.
module tb_seg7_scan_driver;

    localparam int RD = 4;

    localparam logic [6:0] G_BLANK = 7'b1111111;
    localparam logic [6:0] G_DASH  = 7'b1111110;
    localparam logic [6:0] HEXTAB [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load1 = 1'b0, load2 = 1'b0;
    logic [15:0] value1 = '0;
    logic [19:0] value2 = '0;
    logic        mode = 1'b0;
    logic [3:0]  dp = '0;
    logic        blank_lz = 1'b0;
    logic        busy1, busy2, dpn1, dpn2;
    logic [0:6]  disp1, disp2;
    logic [3:0]  an1, an2;

    logic        sel = 1'b0;
    logic [0:6]  disp_m;
    logic        dpn_m;
    logic [3:0]  an_m;
    assign disp_m = sel ? disp2 : disp1;
    assign dpn_m  = sel ? dpn2  : dpn1;
    assign an_m   = sel ? an2   : an1;

    int npass = 0, ntotal = 0;
    int ecount = 0;
    logic [6:0] exp_g [4];
    logic [3:0] exp_dpn;

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) ecount <= 0;
        else     ecount <= ecount + 1;
    end

    seg7_scan_driver #(.DIGITS(4), .DATA_W(16), .REFRESH_DIV(RD)) u_dut (
        .clk(clk), .rst(rst), .load(load1), .value(value1), .mode(mode), .dp(dp),
        .blank_lz(blank_lz), .busy(busy1), .disp(disp1), .dp_n(dpn1), .an(an1)
    );

    seg7_scan_driver #(.DIGITS(4), .DATA_W(20), .REFRESH_DIV(RD)) u_dut20 (
        .clk(clk), .rst(rst), .load(load2), .value(value2), .mode(mode), .dp(dp),
        .blank_lz(blank_lz), .busy(busy2), .disp(disp2), .dp_n(dpn2), .an(an2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Expected digits from plain arithmetic on the value in the chosen base.
    task automatic set_model(input longint unsigned v, input bit m, input logic [3:0] d, input bit b);
        longint unsigned base, pw, lim;
        bit ovf;
        int dig;
        base = m ? 10 : 16;
        lim  = base * base * base * base;
        ovf  = (v >= lim);
        pw   = 1;
        for (int i = 0; i < 4; i++) begin
            dig = int'((v / pw) % base);
            if (ovf)                       exp_g[i] = G_DASH;
            else if (b && i > 0 && v < pw) exp_g[i] = G_BLANK;
            else                           exp_g[i] = HEXTAB[dig];
            pw = pw * base;
        end
        exp_dpn = ~d;
    endtask

    task automatic check_display(input string tag);
        int idx;
        logic [3:0] ea;
        for (int c = 0; c < 4 * RD; c++) begin
            @(negedge clk);
            idx = ((ecount - 1) / RD) % 4;
            ea  = ~(4'b0001 << idx);
            chk({tag, "_an"},  32'(an_m),        32'(ea));
            chk({tag, "_seg"}, 32'(disp_m),      32'(exp_g[idx]));
            chk({tag, "_dp"},  32'(dpn_m),       32'(exp_dpn[idx]));
        end
    endtask

    task automatic do_load(input logic [15:0] v, input bit m, input logic [3:0] d,
                           input bit b, input string tag);
        int n;
        @(negedge clk);
        value1 = v; mode = m; dp = d; blank_lz = b; load1 = 1'b1;
        @(negedge clk);
        load1 = 1'b0;
        n = 0;
        while (busy1 === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_busy_cycles"}, 32'(n), m ? 32'd17 : 32'd2);
        set_model(longint'(v), m, d, b);
        check_display(tag);
    endtask

    initial begin
        int n;
        logic [15:0] rv;
        bit rm, rb;
        logic [3:0] rd;

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_disp", 32'(disp1), 32'(G_BLANK));
        chk("rst_dpn",  32'(dpn1),  32'd1);
        chk("rst_an",   32'(an1),   32'hF);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) exp_g[i] = G_BLANK;
        exp_dpn = 4'hF;
        check_display("idle");

        do_load(16'hA5C3, 1'b0, 4'b0000, 1'b0, "hex_a5c3");
        do_load(16'd42,   1'b1, 4'b0010, 1'b1, "dec_42_blank");
        do_load(16'd10000, 1'b1, 4'b0101, 1'b0, "dec_ovf");
        do_load(16'd0,    1'b1, 4'b0000, 1'b1, "zero_blank");
        do_load(16'd9999, 1'b1, 4'b0000, 1'b1, "dec_9999");
        do_load(16'h0100, 1'b0, 4'b1000, 1'b1, "hex_blank");

        // Hex overflow on the 20-bit instance.
        @(negedge clk);
        value2 = 20'h10000; mode = 1'b0; dp = 4'b0001; blank_lz = 1'b1; load2 = 1'b1;
        @(negedge clk);
        load2 = 1'b0;
        n = 0;
        while (busy2 === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("hex20_busy_cycles", 32'(n), 32'd2);
        set_model(64'h10000, 1'b0, 4'b0001, 1'b1);
        sel = 1'b1;
        check_display("hex20_ovf");
        sel = 1'b0;

        for (int k = 0; k < 10; k++) begin
            rv = 16'($urandom_range(0, 65535));
            if (k % 4 == 0) rv = 16'($urandom_range(0, 120));
            rm = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            rd = 4'($urandom_range(0, 15));
            do_load(rv, rm, rd, rb, $sformatf("rand%0d", k));
        end

        // A second load during conversion must be dropped.
        @(negedge clk);
        value1 = 16'd1234; mode = 1'b1; dp = 4'b0100; blank_lz = 1'b0; load1 = 1'b1;
        @(negedge clk);
        load1 = 1'b0;
        repeat (3) @(negedge clk);
        value1 = 16'd8765; dp = 4'b1111; load1 = 1'b1;
        @(negedge clk);
        load1 = 1'b0;
        n = 4;
        while (busy1 === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("ignore_busy_cycles", 32'(n), 32'd17);
        set_model(64'd1234, 1'b1, 4'b0100, 1'b0);
        check_display("ignore_load");

        // Reset in the middle of a decimal conversion.
        @(negedge clk);
        value1 = 16'd5678; mode = 1'b1; dp = 4'b1111; load1 = 1'b1;
        @(negedge clk);
        load1 = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_busy_before_rst", 32'(busy1), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy1), 32'd0);
        chk("mid_rst_disp", 32'(disp1), 32'(G_BLANK));
        chk("mid_rst_an",   32'(an1),   32'hF);
        chk("mid_rst_dpn",  32'(dpn1),  32'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) exp_g[i] = G_BLANK;
        exp_dpn = 4'hF;
        check_display("after_rst");
        chk("after_rst_busy", 32'(busy1), 32'd0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
